// File: rtl/pipe_hazard_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl_pkg
// Shared constants and types for the pipeline hazard controller:
//   - datapath / register-index widths
//   - default exception entry PC
//   - MDU sequencer state encoding
//   - redirect payload carried by the redirect holder
// -----------------------------------------------------------------------------
package pipe_hazard_ctrl_pkg;

   localparam int unsigned XLEN     = 32;
   localparam int unsigned REG_AW   = 5;
   localparam int unsigned LU_CNT_W = 3;

   localparam logic [XLEN-1:0] EXC_VECTOR_DEF = 32'hBFC0_0380;

   // MDU sequencer states; encodings are shared with software-visible debug
   typedef enum logic [1:0] {
      MDU_IDLE = 2'd0,
      MDU_RUN  = 2'd1,
      MDU_DONE = 2'd2
   } mdu_state_e;

   // Redirect request as held for fetch
   typedef struct packed {
      logic            valid;
      logic [XLEN-1:0] pc;
   } redirect_t;

endpackage : pipe_hazard_ctrl_pkg

// File: rtl/pipe_hazard_ctrl_mdu_seq.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl_mdu_seq
// Start / wait / cancel sequencer for multi-cycle mul/div operations.
// Ports:
//   clk, resetn    clock, asynchronous active-low reset
//   i_mdu_op       execute-stage instruction is a multi-cycle MDU op
//   i_mdu_ready    MDU result valid
//   i_exc          exception or held redirect in progress (aborts the op)
//   o_start_c      one-cycle MDU start pulse (combinational)
//   o_cancel_c     one-cycle MDU abort pulse (combinational)
//   o_ex_req_c     stall request for the execute stage (combinational)
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl_mdu_seq
   import pipe_hazard_ctrl_pkg::*;
(
   input  logic clk,
   input  logic resetn,
   input  logic i_mdu_op,
   input  logic i_mdu_ready,
   input  logic i_exc,
   output logic o_start_c,
   output logic o_cancel_c,
   output logic o_ex_req_c
);

   mdu_state_e r_state;
   mdu_state_e w_state_nxt;

   // State register
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state <= MDU_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state and pulses; EX is released exactly in the DONE cycle
   always_comb begin
      w_state_nxt = r_state;
      o_start_c   = 1'b0;
      o_cancel_c  = 1'b0;
      o_ex_req_c  = 1'b0;

      if (i_exc) begin
         // Abort only an operation actually in flight in the MDU
         w_state_nxt = MDU_IDLE;
         o_cancel_c  = resetn && (r_state == MDU_RUN);
      end else begin
         o_ex_req_c = i_mdu_op && (r_state != MDU_DONE);
         case (r_state)
            MDU_IDLE: begin
               if (i_mdu_op) begin
                  w_state_nxt = MDU_RUN;
                  o_start_c   = resetn;
               end
            end
            MDU_RUN: begin
               if (i_mdu_ready) begin
                  w_state_nxt = MDU_DONE;
               end
            end
            MDU_DONE: begin
               w_state_nxt = MDU_IDLE;
            end
            default: begin
               w_state_nxt = MDU_IDLE;
            end
         endcase
      end
   end

endmodule : pipe_hazard_ctrl_mdu_seq

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
// Pipeline hazard controller: merges external and internal stall sources
// into per-stage stall/flush vectors, sequences multi-cycle MDU ops, inserts
// load-use bubbles and holds exception/ERET redirects until fetch accepts.
// Ports:
//   clk, resetn             clock, asynchronous active-low reset
//   stall_req[NSTAGE]       external per-stage stall requests
//   id_rs, id_rt            decode source registers
//   ex_rd, ex_rmem          execute destination register / is-load
//   mdu_op, mdu_ready       execute MDU op / MDU result valid
//   mdu_start, mdu_cancel   MDU start / abort pulses
//   exc_valid, exc_eret     exception or ERET committed / event is ERET
//   cp0_epc                 ERET return address
//   fetch_ready             fetch accepts a redirect this cycle
//   redirect_valid/_pc      redirect request and target
//   stall[NSTAGE]           per-stage hold
//   flush[NSTAGE]           per-stage bubble insert
// All outputs are combinational and forced to zero while resetn is low.
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int unsigned     NSTAGE     = 5,
   parameter int unsigned     ID_IDX     = 1,
   parameter int unsigned     EX_IDX     = 2,
   parameter int unsigned     MEM_IDX    = 3,
   parameter int unsigned     LOAD_LAT   = 1,
   parameter logic [XLEN-1:0] EXC_VECTOR = EXC_VECTOR_DEF
)
(
   input  logic              clk,
   input  logic              resetn,
   input  logic [NSTAGE-1:0] stall_req,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic              ex_rmem,
   input  logic              mdu_op,
   input  logic              mdu_ready,
   output logic              mdu_start,
   output logic              mdu_cancel,
   input  logic              exc_valid,
   input  logic              exc_eret,
   input  logic [XLEN-1:0]   cp0_epc,
   input  logic              fetch_ready,
   output logic              redirect_valid,
   output logic [XLEN-1:0]   redirect_pc,
   output logic [NSTAGE-1:0] stall,
   output logic [NSTAGE-1:0] flush
);

   // Stage ordering and latency range are fixed at elaboration
   if ((ID_IDX >= EX_IDX) || (EX_IDX >= MEM_IDX) || (MEM_IDX >= NSTAGE) ||
       (LOAD_LAT < 1) || (LOAD_LAT > 7)) begin : g_bad_cfg
      $error("pipe_hazard_ctrl: illegal stage index or LOAD_LAT parameter");
   end

   logic                w_exc;
   logic                w_lu_hit;
   logic                w_lu_req;
   logic                w_mdu_req;
   logic [LU_CNT_W-1:0] r_lu_cnt;
   redirect_t           r_redir;
   logic [XLEN-1:0]     w_target;
   logic [NSTAGE-1:0]   w_req;
   logic [NSTAGE-1:0]   w_stall_raw;
   logic [NSTAGE-1:0]   w_flush_raw;

   // An exception in MEM or a held redirect overrides all stalls
   assign w_exc = exc_valid || r_redir.valid;

   // Load in EX feeding a source register of the instruction in ID
   assign w_lu_hit = ex_rmem && (ex_rd != '0) && ((ex_rd == id_rs) || (ex_rd == id_rt));
   assign w_lu_req = w_lu_hit || (r_lu_cnt != '0);

   assign w_target = exc_eret ? cp0_epc : EXC_VECTOR;

   pipe_hazard_ctrl_mdu_seq u_mdu_seq (
      .clk         (clk),
      .resetn      (resetn),
      .i_mdu_op    (mdu_op),
      .i_mdu_ready (mdu_ready),
      .i_exc       (w_exc),
      .o_start_c   (mdu_start),
      .o_cancel_c  (mdu_cancel),
      .o_ex_req_c  (w_mdu_req)
   );

   // Merge stall sources, propagate toward IF, bubble behind the boundary
   always_comb begin
      logic acc;
      w_req         = stall_req;
      w_req[ID_IDX] = stall_req[ID_IDX] | w_lu_req;
      w_req[EX_IDX] = stall_req[EX_IDX] | w_mdu_req;

      acc         = 1'b0;
      w_stall_raw = '0;
      for (int k = int'(NSTAGE) - 1; k >= 0; k--) begin
         acc            = acc | w_req[k];
         w_stall_raw[k] = acc;
      end

      w_flush_raw = '0;
      for (int k = 0; k < int'(NSTAGE) - 1; k++) begin
         w_flush_raw[k+1] = w_stall_raw[k] & ~w_stall_raw[k+1];
      end
   end

   // Final stall/flush with exception override and reset gating
   always_comb begin
      stall = '0;
      flush = '0;
      if (resetn) begin
         if (w_exc) begin
            flush = '1;
         end else begin
            stall = w_stall_raw;
            flush = w_flush_raw;
         end
      end
   end

   // Remaining load-use bubbles; only counts while the bubble moves into EX
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_lu_cnt <= '0;
      end else if (w_exc) begin
         r_lu_cnt <= '0;
      end else if (w_lu_hit) begin
         r_lu_cnt <= LU_CNT_W'(LOAD_LAT - 1);
      end else if ((r_lu_cnt != '0) && !w_stall_raw[EX_IDX]) begin
         r_lu_cnt <= r_lu_cnt - LU_CNT_W'(1);
      end
   end

   // Redirect holder; a new exception while holding keeps the first target
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_redir <= '0;
      end else if (r_redir.valid) begin
         if (fetch_ready) begin
            r_redir.valid <= 1'b0;
         end
      end else if (exc_valid && !fetch_ready) begin
         r_redir.valid <= 1'b1;
         r_redir.pc    <= w_target;
      end
   end

   assign redirect_valid = resetn && w_exc;

   // Held target wins over a live exception; idle drives zero
   always_comb begin
      redirect_pc = '0;
      if (resetn) begin
         if (r_redir.valid) begin
            redirect_pc = r_redir.pc;
         end else if (exc_valid) begin
            redirect_pc = w_target;
         end
      end
   end

endmodule : pipe_hazard_ctrl

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
// Self-checking bench: two controllers (LOAD_LAT = 1 and 3) share stimulus.
// Each cycle's expected outputs are queued when inputs are driven and popped
// and compared on the following falling edge.
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

   localparam logic [31:0] VEC   = 32'hBFC0_0380;
   localparam logic [4:0]  ST_ID = 5'b00011;
   localparam logic [4:0]  FL_ID = 5'b00100;
   localparam logic [4:0]  ST_EX = 5'b00111;
   localparam logic [4:0]  FL_EX = 5'b01000;

   logic        clk    = 1'b0;
   logic        resetn = 1'b0;
   logic [4:0]  stall_req;
   logic [4:0]  id_rs, id_rt, ex_rd;
   logic        ex_rmem, mdu_op, mdu_ready;
   logic        exc_valid, exc_eret, fetch_ready;
   logic [31:0] cp0_epc;

   logic [4:0]  stall1, flush1, stall3, flush3;
   logic        start1, cancel1, rv1, start3, cancel3, rv3;
   logic [31:0] rpc1, rpc3;

   typedef struct {
      string       tag;
      logic [4:0]  st, fl, st3, fl3;
      logic        start, cancel, rv;
      logic [31:0] rpc;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   logic [4:0] sr_tab [4] = '{5'b00100, 5'b10000, 5'b00001, 5'b01010};
   logic [4:0] st_tab [4] = '{5'b00111, 5'b11111, 5'b00001, 5'b01111};
   logic [4:0] fl_tab [4] = '{5'b01000, 5'b00000, 5'b00010, 5'b10000};

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.LOAD_LAT(1)) u_dut (
      .clk(clk), .resetn(resetn), .stall_req(stall_req),
      .id_rs(id_rs), .id_rt(id_rt), .ex_rd(ex_rd), .ex_rmem(ex_rmem),
      .mdu_op(mdu_op), .mdu_ready(mdu_ready),
      .mdu_start(start1), .mdu_cancel(cancel1),
      .exc_valid(exc_valid), .exc_eret(exc_eret), .cp0_epc(cp0_epc),
      .fetch_ready(fetch_ready), .redirect_valid(rv1), .redirect_pc(rpc1),
      .stall(stall1), .flush(flush1)
   );

   pipe_hazard_ctrl #(.LOAD_LAT(3)) u_dut3 (
      .clk(clk), .resetn(resetn), .stall_req(stall_req),
      .id_rs(id_rs), .id_rt(id_rt), .ex_rd(ex_rd), .ex_rmem(ex_rmem),
      .mdu_op(mdu_op), .mdu_ready(mdu_ready),
      .mdu_start(start3), .mdu_cancel(cancel3),
      .exc_valid(exc_valid), .exc_eret(exc_eret), .cp0_epc(cp0_epc),
      .fetch_ready(fetch_ready), .redirect_valid(rv3), .redirect_pc(rpc3),
      .stall(stall3), .flush(flush3)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
      end
   endtask

   task automatic compare(input exp_t e);
      check({e.tag, ".stall"},   32'(stall1),  32'(e.st));
      check({e.tag, ".flush"},   32'(flush1),  32'(e.fl));
      check({e.tag, ".start"},   32'(start1),  32'(e.start));
      check({e.tag, ".cancel"},  32'(cancel1), 32'(e.cancel));
      check({e.tag, ".rvalid"},  32'(rv1),     32'(e.rv));
      check({e.tag, ".rpc"},     rpc1,         e.rpc);
      check({e.tag, ".stall3"},  32'(stall3),  32'(e.st3));
      check({e.tag, ".flush3"},  32'(flush3),  32'(e.fl3));
      check({e.tag, ".start3"},  32'(start3),  32'(e.start));
      check({e.tag, ".cancel3"}, 32'(cancel3), 32'(e.cancel));
      check({e.tag, ".rvalid3"}, 32'(rv3),     32'(e.rv));
      check({e.tag, ".rpc3"},    rpc3,         e.rpc);
   endtask

   function automatic exp_t mk(input string tag, input logic [4:0] st, input logic [4:0] fl,
                               input logic [4:0] st3, input logic [4:0] fl3,
                               input logic start, input logic cancel,
                               input logic rv, input logic [31:0] rpc);
      exp_t e;
      e.tag = tag; e.st = st; e.fl = fl; e.st3 = st3; e.fl3 = fl3;
      e.start = start; e.cancel = cancel; e.rv = rv; e.rpc = rpc;
      return e;
   endfunction

   function automatic exp_t same(input string tag, input logic [4:0] st, input logic [4:0] fl);
      return mk(tag, st, fl, st, fl, 1'b0, 1'b0, 1'b0, 32'h0);
   endfunction

   function automatic exp_t exc_e(input string tag, input logic [31:0] pc, input logic cancel);
      return mk(tag, 5'h00, 5'h1F, 5'h00, 5'h1F, 1'b0, cancel, 1'b1, pc);
   endfunction

   function automatic exp_t start_e(input string tag);
      return mk(tag, ST_EX, FL_EX, ST_EX, FL_EX, 1'b1, 1'b0, 1'b0, 32'h0);
   endfunction

   // Queue this cycle's expectation, then advance to the next cycle
   task automatic cyc(input exp_t e);
      sb_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic clr_in();
      stall_req   = '0;
      id_rs       = '0;
      id_rt       = '0;
      ex_rd       = '0;
      ex_rmem     = 1'b0;
      mdu_op      = 1'b0;
      mdu_ready   = 1'b0;
      exc_valid   = 1'b0;
      exc_eret    = 1'b0;
      cp0_epc     = '0;
      fetch_ready = 1'b1;
   endtask

   always @(negedge clk) begin
      if (sb_q.size() != 0) begin
         compare(sb_q.pop_front());
      end
   end

   initial begin
      clr_in();
      stall_req = 5'h1F; mdu_op = 1'b1; exc_valid = 1'b1; fetch_ready = 1'b0;
      ex_rmem = 1'b1; ex_rd = 5'd5; id_rs = 5'd5;
      @(posedge clk);
      #1;
      cyc(same("rst_hold", 5'h00, 5'h00));
      clr_in();
      resetn = 1'b1;
      cyc(same("idle", 5'h00, 5'h00));

      // External stall requests
      for (int i = 0; i < 4; i++) begin
         stall_req = sr_tab[i];
         cyc(same($sformatf("sreq%0d", i), st_tab[i], fl_tab[i]));
      end
      clr_in();

      // Load-use via rs: one bubble at LOAD_LAT=1, three at LOAD_LAT=3
      ex_rmem = 1'b1; ex_rd = 5'd5; id_rs = 5'd5;
      cyc(same("lu_hit", ST_ID, FL_ID));
      clr_in();
      cyc(mk("lu_b1", 5'h00, 5'h00, ST_ID, FL_ID, 1'b0, 1'b0, 1'b0, 32'h0));
      cyc(mk("lu_b2", 5'h00, 5'h00, ST_ID, FL_ID, 1'b0, 1'b0, 1'b0, 32'h0));
      cyc(same("lu_end", 5'h00, 5'h00));
      // r0 never creates a hazard
      ex_rmem = 1'b1; ex_rd = 5'd0; id_rs = 5'd0;
      cyc(same("lu_r0", 5'h00, 5'h00));
      clr_in();
      cyc(same("lu_r0_after", 5'h00, 5'h00));
      // Non-load with matching register
      ex_rd = 5'd7; id_rs = 5'd7;
      cyc(same("lu_noload", 5'h00, 5'h00));
      clr_in();
      // Load-use via rt, with EX held one cycle by an external request
      ex_rmem = 1'b1; ex_rd = 5'd7; id_rs = 5'd3; id_rt = 5'd7;
      cyc(same("lu_rt", ST_ID, FL_ID));
      clr_in();
      stall_req = 5'b00100;
      cyc(same("lu_exhold", ST_EX, FL_EX));
      clr_in();
      cyc(mk("lu_rt_b1", 5'h00, 5'h00, ST_ID, FL_ID, 1'b0, 1'b0, 1'b0, 32'h0));
      cyc(mk("lu_rt_b2", 5'h00, 5'h00, ST_ID, FL_ID, 1'b0, 1'b0, 1'b0, 32'h0));
      cyc(same("lu_rt_end", 5'h00, 5'h00));

      // MDU, ready ten cycles after start: EX stalled eleven cycles
      mdu_op = 1'b1;
      cyc(start_e("mdu_start"));
      for (int i = 1; i < 10; i++) begin
         cyc(same($sformatf("mdu_run%0d", i), ST_EX, FL_EX));
      end
      mdu_ready = 1'b1;
      cyc(same("mdu_rdy", ST_EX, FL_EX));
      mdu_ready = 1'b0;
      cyc(same("mdu_done", 5'h00, 5'h00));
      mdu_op = 1'b0;
      cyc(same("mdu_idle", 5'h00, 5'h00));

      // MDU, ready on the cycle after start: EX stalled two cycles
      mdu_op = 1'b1;
      cyc(start_e("mdu2_start"));
      mdu_ready = 1'b1;
      cyc(same("mdu2_rdy", ST_EX, FL_EX));
      mdu_ready = 1'b0;
      cyc(same("mdu2_done", 5'h00, 5'h00));
      mdu_op = 1'b0;
      cyc(same("mdu2_idle", 5'h00, 5'h00));

      // Exception in the fourth RUN cycle cancels the MDU
      mdu_op = 1'b1;
      cyc(start_e("exm_start"));
      for (int i = 1; i < 4; i++) begin
         cyc(same($sformatf("exm_run%0d", i), ST_EX, FL_EX));
      end
      exc_valid = 1'b1;
      cyc(exc_e("exm_exc", VEC, 1'b1));
      clr_in();
      cyc(same("exm_after", 5'h00, 5'h00));
      mdu_op = 1'b1;
      cyc(start_e("exm_restart"));
      mdu_ready = 1'b1;
      cyc(same("exm_rdy", ST_EX, FL_EX));
      mdu_ready = 1'b0;
      cyc(same("exm_done", 5'h00, 5'h00));
      clr_in();

      // ERET while fetch is busy for three cycles
      exc_valid = 1'b1; exc_eret = 1'b1; cp0_epc = 32'h8000_1234; fetch_ready = 1'b0;
      cyc(exc_e("eret0", 32'h8000_1234, 1'b0));
      clr_in();
      fetch_ready = 1'b0; cp0_epc = 32'hDEAD_BEEF; stall_req = 5'h1F;
      ex_rmem = 1'b1; ex_rd = 5'd5; id_rs = 5'd5;
      cyc(exc_e("eret_hold1", 32'h8000_1234, 1'b0));
      clr_in();
      fetch_ready = 1'b0; exc_valid = 1'b1; cp0_epc = 32'hDEAD_BEEF;
      cyc(exc_e("eret_hold2", 32'h8000_1234, 1'b0));
      clr_in();
      cyc(exc_e("eret_accept", 32'h8000_1234, 1'b0));
      cyc(same("eret_after", 5'h00, 5'h00));

      // Reset asserted while the MDU is running
      mdu_op = 1'b1;
      cyc(start_e("rr_start"));
      cyc(same("rr_run", ST_EX, FL_EX));
      resetn = 1'b0;
      #1;
      compare(same("rst_run", 5'h00, 5'h00));
      @(posedge clk);
      #1;
      clr_in();
      resetn = 1'b1;
      cyc(same("rr_rel", 5'h00, 5'h00));
      mdu_op = 1'b1;
      cyc(start_e("rr_restart"));
      mdu_ready = 1'b1;
      cyc(same("rr_rdy", ST_EX, FL_EX));
      mdu_ready = 1'b0;
      cyc(same("rr_done", 5'h00, 5'h00));
      clr_in();

      // Reset asserted while a redirect is held
      exc_valid = 1'b1; fetch_ready = 1'b0;
      cyc(exc_e("rp_set", VEC, 1'b0));
      exc_valid = 1'b0;
      resetn = 1'b0;
      #1;
      compare(same("rst_pend", 5'h00, 5'h00));
      @(posedge clk);
      #1;
      resetn = 1'b1;
      cyc(same("rp_rel", 5'h00, 5'h00));
      clr_in();
      cyc(same("final_idle", 5'h00, 5'h00));

      @(posedge clk);
      #1;
      check("sb_drain", 32'(sb_q.size()), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_pipe_hazard_ctrl
